fp_ramp_tracker: RTL and testbench
==================================

Name: fp_ramp_tracker

Overview:
Inverse companion of the log-compressed up/down counter used in the analog toolkit peripheral.
- Accepts an 8-bit compressed code {sign, exponent[3:0], mantissa[2:0]} over a valid/ready handshake.
- Expands the code to a 30-bit two's-complement linear target.
- Slews an internal 30-bit position toward that target, one step per step_en pulse.
- Step size uses the same 8-bit step encoding as the counter.
- Drives DAC/PWM set-points with controlled ramp rate.

Parameters:
RESET_POS, 30'd0, value loaded into position on reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
code_in  in  8  compressed target {sign, exp[3:0], mant[2:0]}
code_valid  in  1  code_in offered
code_ready  out  1  block can accept a code; high only in IDLE
step  in  8  step code; inc = ({1'b1, step[3:0]}) << step[7:4], 20 bits unsigned
step_en  in  1  advance one step this cycle
position  out  30  current linear position, two's complement
target  out  30  latched expanded target
busy  out  1  high in RAMP
done  out  1  one-cycle pulse when position reaches target

Behaviour:
- Reset (rst_n=0 at clk edge) gives:
  - position=RESET_POS, target=0, state IDLE, busy=0, done=0, code_ready=1.
  - Applies mid-ramp too: any ramp in progress is abandoned.
- Decode is combinational from code_in; the result is registered into target on accept (code_valid & code_ready).
- Decode, sign=0, e=exp:
  - e=0: value = mant<<11.
  - e>=1: bit(13+e)=1, bits(12+e:10+e)=mant, all other bits 0.
- Decode, sign=1, s=~exp:
  - bits 29 down to 14+s = 1.
  - s>=1: bit(13+s)=0.
  - Then bits(12+s:10+s)=mant (for s=0: bits 13:11=mant).
  - Remaining lower bits = 0.
- Decoded lower bits are truncated to zero. Re-encoding a decoded value yields the same code.
- FSM states: IDLE, RAMP.
- IDLE:
  - code_ready=1.
  - On accept at edge N: target updates at N.
  - If decoded value == position, done pulses in cycle N+1 and the block stays IDLE.
  - Otherwise the block enters RAMP (busy=1 from cycle N+1).
  - step_en is ignored in IDLE.
- RAMP:
  - code_ready=0; code_valid is ignored and must be held by the source.
  - On step_en, with diff = target - position (signed, 31-bit):
    - If |diff| <= inc: position <= target, done=1 next cycle, return to IDLE.
    - Else if diff > 0: position += inc.
    - Else: position -= inc.
  - No step_en: hold.
- No wrap-around: the snap rule guarantees position never crosses target. Intermediate arithmetic is 31-bit, so no overflow is possible.
- step may change between step_en pulses; each step uses the step value sampled in its own cycle.
- done is a pulse, high for exactly 1 cycle; busy falls in the same cycle done rises.

Decomposition:
- Shared package holds:
  - Field positions of the compressed code (SIGN_BIT=7, EXP_MSB=6, EXP_LSB=3, MANT_MSB=2).
  - Counter width CW=30, increment width INC_W=20, base mantissa offset MANT_BASE=11.
  - FSM state enum.
- One natural sub-module: fp_code_expand, a pure combinational 8-bit code to 30-bit linear decode.
  - Shared with any future block that consumes the compressed code.
  - Unit-tested standalone against re-encoding.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles, release.
  - Expect: position=0, target=0, busy=0, done=0, code_ready=1.
- Decode sweep (via target after accept):
  - Codes: 0x00, 0x07, 0x0D, 0x7F, 0xFF, 0x80.
  - Expect: 0x0000000, 0x0003800, 0x0006800, 0x1E000000, 0x3FFFF800, 0x20000000.
  - All 256 codes must re-encode to themselves.
- Up-ramp:
  - Stimulus: from 0, code 0x0D, step=0x40 (inc=256), step_en every cycle.
  - Expect: exactly 104 steps to 26624; done pulses once; busy low afterwards; position monotonic.
- Snap:
  - Stimulus: from 0, code 0x07, step=0xF0 (inc=524288).
  - Expect: one step_en sets position=14336 exactly; done next cycle.
- Down-ramp / negative:
  - Stimulus: from 14336, code 0xFF, step=0x00 (inc=16).
  - Expect: 1024 steps to 0x3FFFF800 (-2048); never below target.
- Handshake, reset, equality:
  - Stimulus: code_valid asserted while busy.
    - Expect: code_ready=0, target unchanged.
  - Stimulus: rst_n low mid-ramp.
    - Expect: position=0, IDLE.
  - Stimulus: accept code 0x00 at position 0.
    - Expect: done pulse, busy never rises.

Source files
------------

// File: rtl/fp_ramp_tracker_pkg.sv
// Shared definitions for the compressed-code ramp tracker: code field
// positions, datapath widths, FSM states and the step-size decode.
package fp_ramp_tracker_pkg;

   // Compressed code layout {sign, exp[3:0], mant[2:0]}
   localparam int unsigned SIGN_BIT  = 7;
   localparam int unsigned EXP_MSB   = 6;
   localparam int unsigned EXP_LSB   = 3;
   localparam int unsigned MANT_MSB  = 2;

   // Linear position width, step increment width, mantissa shift for exp 0
   localparam int unsigned CW        = 30;
   localparam int unsigned INC_W     = 20;
   localparam int unsigned MANT_BASE = 11;

   typedef enum logic [0:0] {
      StIdle,
      StRamp
   } state_e;

   // Step code to unsigned increment: {1, step[3:0]} << step[7:4]
   function automatic logic [INC_W-1:0] step_inc(input logic [7:0] step_code);
      logic [INC_W-1:0] base;
      base = INC_W'({1'b1, step_code[3:0]});
      return base << step_code[7:4];
   endfunction

endpackage

// File: rtl/fp_code_expand.sv
// Combinational expansion of an 8-bit compressed code into a 30-bit
// two's-complement linear value. Lower bits below the mantissa are zero.
module fp_code_expand
   import fp_ramp_tracker_pkg::*;
(
   input  logic [7:0]    code,
   output logic [CW-1:0] value
);

   logic          sgn;
   logic [3:0]    ex;
   logic [2:0]    mant;
   logic [3:0]    s;
   logic [4:0]    pos_sh;
   logic [4:0]    lead_sh;
   logic [4:0]    mant_sh;

   // Field extraction and shift amounts
   always_comb begin
      sgn     = code[SIGN_BIT];
      ex      = code[EXP_MSB:EXP_LSB];
      mant    = code[MANT_MSB:0];
      s       = ~ex;
      pos_sh  = 5'd10 + {1'b0, ex};
      lead_sh = 5'd14 + {1'b0, s};
      // s=0 and s=1 both place the mantissa at bits 13:11
      mant_sh = (s == 4'd0) ? 5'(MANT_BASE) : (5'd10 + {1'b0, s});
   end

   // Value assembly
   always_comb begin
      value = '0;
      if (!sgn) begin
         if (ex == 4'd0) begin
            value = CW'(mant) << MANT_BASE;
         end else begin
            // Implicit leading one sits just above the mantissa
            value = CW'({1'b1, mant}) << pos_sh;
         end
      end else begin
         // Ones from bit 29 down to 14+s; bit 13+s left at zero for s>=1
         value = ({CW{1'b1}} << lead_sh) | (CW'(mant) << mant_sh);
      end
   end

endmodule

// File: rtl/fp_ramp_tracker.sv
// Slews a 30-bit position toward a target given as a compressed code,
// one step per step_en pulse, snapping onto the target on the final step.
module fp_ramp_tracker
   import fp_ramp_tracker_pkg::*;
#(
   parameter logic [CW-1:0] RESET_POS = 30'd0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    code_in,
   input  logic          code_valid,
   output logic          code_ready,
   input  logic [7:0]    step,
   input  logic          step_en,
   output logic [CW-1:0] position,
   output logic [CW-1:0] target,
   output logic          busy,
   output logic          done
);

   state_e            state_q, state_d;
   logic [CW-1:0]     position_q, position_d;
   logic [CW-1:0]     target_q, target_d;
   logic              done_q, done_d;

   logic [CW-1:0]     expanded;
   logic [INC_W-1:0]  inc;
   logic [CW:0]       inc_ext;
   logic signed [CW:0] diff;
   logic [CW:0]       abs_diff;
   logic [CW-1:0]     pos_up;
   logic [CW-1:0]     pos_dn;

   fp_code_expand u_expand (
      .code  (code_in),
      .value (expanded)
   );

   // Distance to target and candidate next positions (31-bit, no overflow)
   always_comb begin
      inc      = step_inc(step);
      inc_ext  = {{(CW + 1 - INC_W){1'b0}}, inc};
      diff     = $signed({target_q[CW-1], target_q}) - $signed({position_q[CW-1], position_q});
      abs_diff = diff[CW] ? 31'(-diff) : 31'(diff);
      pos_up   = position_q + {{(CW - INC_W){1'b0}}, inc};
      pos_dn   = position_q - {{(CW - INC_W){1'b0}}, inc};
   end

   // Next-state logic: accept in idle, step or snap in ramp
   always_comb begin
      state_d    = state_q;
      position_d = position_q;
      target_d   = target_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (code_valid) begin
               target_d = expanded;
               if (expanded == position_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StRamp;
               end
            end
         end
         StRamp: begin
            if (step_en) begin
               if (abs_diff <= inc_ext) begin
                  position_d = target_q;
                  done_d     = 1'b1;
                  state_d    = StIdle;
               end else if (!diff[CW]) begin
                  position_d = pos_up;
               end else begin
                  position_d = pos_dn;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         position_q <= RESET_POS;
         target_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         position_q <= position_d;
         target_q   <= target_d;
         done_q     <= done_d;
      end
   end

   // Registered-state outputs
   always_comb begin
      code_ready = (state_q == StIdle);
      busy       = (state_q == StRamp);
      done       = done_q;
      position   = position_q;
      target     = target_q;
   end

endmodule

// File: tb/tb_fp_ramp_tracker.sv
// Self-checking bench for fp_ramp_tracker: a behavioural model checked every
// cycle, directed decode/ramp scenarios, and randomized ramps.
module tb_fp_ramp_tracker;

   logic        clk;
   logic        rst_n;
   logic [7:0]  code_in;
   logic        code_valid;
   logic        code_ready;
   logic [7:0]  step;
   logic        step_en;
   logic [29:0] position;
   logic [29:0] target;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   longint m_pos, m_tgt;
   bit     m_ramp, m_done;
   bit     model_ok = 1'b0;

   fp_ramp_tracker #(
      .RESET_POS (30'd0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .step       (step),
      .step_en    (step_en),
      .position   (position),
      .target     (target),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Code to signed linear value, as a sum of powers of two
   function automatic longint dec(input logic [7:0] c);
      int e, m, s;
      e = int'(c[6:3]);
      m = int'(c[2:0]);
      if (!c[7]) begin
         if (e == 0) return longint'(m) * 2048;
         return longint'(8 + m) * (longint'(1) << (10 + e));
      end
      s = 15 - e;
      if (s == 0) return -16384 + longint'(m) * 2048;
      return -(longint'(1) << (14 + s)) + longint'(m) * (longint'(1) << (10 + s));
   endfunction

   // Linear value back to code
   function automatic logic [7:0] enc(input logic [29:0] v);
      logic signed [29:0] sv;
      longint x;
      int p, z, s, mant;
      logic [7:0] r;
      sv = v;
      x  = longint'(sv);
      r  = 8'h00;
      if (x >= 0) begin
         if (x < 16384) begin
            r[2:0] = 3'(int'(x / 2048));
         end else begin
            p = 14;
            for (int b = 28; b >= 14; b--) begin
               if (x >= (longint'(1) << b)) begin
                  p = b;
                  break;
               end
            end
            r[6:3] = 4'(p - 13);
            mant   = int'((x >> (p - 3)) & 7);
            r[2:0] = 3'(mant);
         end
      end else begin
         r[7] = 1'b1;
         z = -1;
         for (int b = 28; b >= 0; b--) begin
            if (!v[b]) begin
               z = b;
               break;
            end
         end
         if (z >= 14) begin
            s      = z - 13;
            r[2:0] = v[z-1 -: 3];
         end else begin
            s      = 0;
            r[2:0] = v[13:11];
         end
         r[6:3] = 4'(15 - s);
      end
      return r;
   endfunction

   function automatic longint inc_of(input logic [7:0] s);
      return longint'(16 + int'(s[3:0])) * (longint'(1) << s[7:4]);
   endfunction

   // Model update on every active edge
   initial begin
      longint d, a, inc;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_pos = 0; m_tgt = 0; m_ramp = 0; m_done = 0; model_ok = 1'b1;
         end else if (model_ok) begin
            m_done = 0;
            if (!m_ramp) begin
               if (code_valid) begin
                  m_tgt = dec(code_in);
                  if (m_tgt == m_pos) m_done = 1;
                  else m_ramp = 1;
               end
            end else if (step_en) begin
               d   = m_tgt - m_pos;
               a   = (d < 0) ? -d : d;
               inc = inc_of(step);
               if (a <= inc) begin
                  m_pos = m_tgt; m_done = 1; m_ramp = 0;
               end else begin
                  m_pos = (d > 0) ? m_pos + inc : m_pos - inc;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      logic [29:0] ep, et;
      forever begin
         @(negedge clk);
         if (model_ok) begin
            ep = m_pos[29:0];
            et = m_tgt[29:0];
            chk("cyc_position",   32'(position),   32'(ep));
            chk("cyc_target",     32'(target),     32'(et));
            chk("cyc_busy",       32'(busy),       32'(m_ramp));
            chk("cyc_done",       32'(done),       32'(m_done));
            chk("cyc_code_ready", 32'(code_ready), 32'(!m_ramp));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic accept(input logic [7:0] c);
      int w;
      w = 0;
      while (!code_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (!code_ready) chk("accept_ready_timeout", 32'(code_ready), 32'd1);
      code_in    = c;
      code_valid = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
   endtask

   task automatic run_ramp(input logic [7:0] st, input int bound, input bit up,
                           output int steps, output int dones, output bit mono_ok);
      longint prev, cur, tg;
      steps   = 0;
      dones   = 0;
      mono_ok = 1'b1;
      tg      = longint'($signed(target));
      prev    = longint'($signed(position));
      step    = st;
      while (busy && steps < bound) begin
         step_en = 1'b1;
         steps++;
         @(negedge clk);
         cur = longint'($signed(position));
         if (up ? (cur <= prev || cur > tg) : (cur >= prev || cur < tg)) mono_ok = 1'b0;
         prev = cur;
         if (done) dones++;
      end
      step_en = 1'b0;
      chk("ramp_finished_busy", 32'(busy), 32'd0);
      repeat (3) begin
         @(negedge clk);
         if (done) dones++;
      end
   endtask

   function automatic logic [7:0] rand_code();
      logic [7:0] c;
      c[7]   = 1'($urandom_range(0, 1));
      c[6:3] = c[7] ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 9));
      c[2:0] = 3'($urandom_range(0, 7));
      return c;
   endfunction

   function automatic logic [7:0] rand_step();
      logic [7:0] s;
      s[7:4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(11, 15));
      s[3:0] = 4'($urandom_range(0, 15));
      return s;
   endfunction

   logic [7:0]  sweep_codes [6] = '{8'h00, 8'h07, 8'h0D, 8'h7F, 8'hFF, 8'h80};
   logic [29:0] sweep_vals  [6] = '{30'h0000000, 30'h0003800, 30'h0006800,
                                    30'h1E000000, 30'h3FFFF800, 30'h20000000};

   initial begin
      int steps, dones, cyc;
      bit mono;
      longint dv;
      logic [7:0] prev_code, c;

      rst_n = 1'b0; code_valid = 1'b0; code_in = 8'h00; step = 8'h00; step_en = 1'b0;

      // Reset held for two cycles
      repeat (2) @(negedge clk);
      chk("reset_position",   32'(position),   32'd0);
      chk("reset_target",     32'(target),     32'd0);
      chk("reset_busy",       32'(busy),       32'd0);
      chk("reset_done",       32'(done),       32'd0);
      chk("reset_code_ready", 32'(code_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Decode sweep against literal values; also pins the model decoder/encoder
      for (int i = 0; i < 6; i++) begin
         pulse_reset();
         accept(sweep_codes[i]);
         chk("sweep_target", 32'(target), 32'(sweep_vals[i]));
         dv = dec(sweep_codes[i]);
         chk("model_dec", 32'(dv[29:0]), 32'(sweep_vals[i]));
         chk("model_enc", 32'(enc(sweep_vals[i])), 32'(sweep_codes[i]));
         if (i == 0) begin
            // Equal to position: done pulse, no ramp
            chk("eq_done", 32'(done), 32'd1);
            chk("eq_busy", 32'(busy), 32'd0);
            repeat (2) begin
               @(negedge clk);
               chk("eq_busy_after", 32'(busy), 32'd0);
               chk("eq_done_after", 32'(done), 32'd0);
            end
         end
      end

      // Every code must re-encode to itself through the latched target
      for (int k = 0; k < 256; k++) begin
         pulse_reset();
         accept(8'(k));
         chk("reencode", 32'(enc(target)), 32'(k));
      end

      // Up-ramp: 0 -> 26624 with inc 256
      pulse_reset();
      accept(8'h0D);
      run_ramp(8'h40, 2000, 1'b1, steps, dones, mono);
      chk("up_steps",    32'(steps),    32'd104);
      chk("up_dones",    32'(dones),    32'd1);
      chk("up_mono",     32'(mono),     32'd1);
      chk("up_position", 32'(position), 32'd26624);

      // Snap: one oversized step lands exactly on 14336
      pulse_reset();
      accept(8'h07);
      run_ramp(8'hF0, 10, 1'b1, steps, dones, mono);
      chk("snap_steps",    32'(steps),    32'd1);
      chk("snap_dones",    32'(dones),    32'd1);
      chk("snap_position", 32'(position), 32'd14336);

      // Down-ramp from 14336 to -2048 with inc 16
      accept(8'hFF);
      run_ramp(8'h00, 3000, 1'b0, steps, dones, mono);
      chk("down_steps",    32'(steps),    32'd1024);
      chk("down_dones",    32'(dones),    32'd1);
      chk("down_mono",     32'(mono),     32'd1);
      chk("down_position", 32'(position), 32'h3FFFF800);

      // Offered code while busy is ignored
      pulse_reset();
      accept(8'h7F);
      code_in = 8'h00; code_valid = 1'b1; step_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hs_ready", 32'(code_ready), 32'd0);
         chk("hs_target", 32'(target), 32'h1E000000);
      end
      code_valid = 1'b0;

      // Reset mid-ramp abandons the ramp
      step = 8'hF0; step_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; step_en = 1'b0;
      chk("mid_rst_position", 32'(position),   32'd0);
      chk("mid_rst_busy",     32'(busy),       32'd0);
      chk("mid_rst_ready",    32'(code_ready), 32'd1);
      chk("mid_rst_target",   32'(target),     32'd0);

      // Randomized chained ramps
      pulse_reset();
      prev_code = 8'h00;
      for (int t = 0; t < 30; t++) begin
         c = ($urandom_range(0, 7) == 0) ? prev_code : rand_code();
         accept(c);
         prev_code = c;
         cyc = 0;
         while (busy && cyc < 5000) begin
            step       = rand_step();
            step_en    = ($urandom_range(0, 3) != 0);
            code_valid = 1'($urandom_range(0, 1));
            code_in    = 8'($urandom);
            @(negedge clk);
            cyc++;
         end
         step_en = 1'b0;
         code_valid = 1'b0;
         chk("rand_ramp_end", 32'(busy), 32'd0);
         chk("rand_final_pos", 32'(position), 32'(target));
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
